// File: rtl/clock_enable_pkg.sv
// Shared constants for the clock enable bank: default widths, reset divisor
// and the named divisors used by the board-level consumers (100 MHz base clock).
package clock_enable_pkg;

  localparam int unsigned CNT_W_DEFAULT     = 24;
  localparam int unsigned RESET_DIV_DEFAULT = 12500;

  // Named divisors for the standard consumers of the bank
  localparam int unsigned DIV_PIXEL    = 4;        // 25 MHz pixel enable
  localparam int unsigned DIV_GAME     = 1666667;  // 60 Hz game update
  localparam int unsigned DIV_SEG      = 12500;    // display mux rate
  localparam int unsigned DIV_DEBOUNCE = 500000;   // debounce sample rate

endpackage

// File: rtl/clock_enable_channel.sv
// One divider channel: counter, one-cycle tick enable and toggled square wave.
// The divisor is loadable at runtime; a divisor of zero halts the channel.
module clock_enable_channel
  import clock_enable_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEFAULT,
  parameter int unsigned RESET_DIV = RESET_DIV_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o,
  output logic             clk_o,
  output logic             active_o
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(RESET_DIV);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic             active_q, active_d;

  // Next-state: load beats sync, sync beats the run enable, then normal count
  always_comb begin
    div_d    = div_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    clk_d    = clk_q;
    active_d = active_q;
    if (load_i) begin
      div_d    = div_i;
      cnt_d    = '0;
      clk_d    = 1'b0;
      active_d = (div_i != '0);
    end else if (sync_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (!en_i) begin
      cnt_d = cnt_q;
    end else if (div_q == '0) begin
      cnt_d = '0;
    end else if (cnt_q == div_q - CNT_W'(1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      clk_d  = ~clk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset to the reset divisor
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q    <= RST_DIV;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      clk_q    <= 1'b0;
      active_q <= (RST_DIV != '0);
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      clk_q    <= clk_d;
      active_q <= active_d;
    end
  end

  assign tick_o   = tick_q;
  assign clk_o    = clk_q;
  assign active_o = active_q;

endmodule

// File: rtl/clock_enable_bank.sv
// Multi-channel clock enable bank: NUM_CH independent divider channels sharing
// one clock, run enable, phase-align pulse and reset. clk_out is a registered
// enable/pin signal and is never used as a clock.
module clock_enable_bank
  import clock_enable_pkg::*;
#(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT,
  parameter int unsigned RESET_DIV = RESET_DIV_DEFAULT
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sync,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       active
);

  // One channel per divisor slice
  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    clock_enable_channel #(
      .CNT_W     (CNT_W),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk_i    (clk_in),
      .rst_i    (rst),
      .en_i     (en),
      .sync_i   (sync),
      .load_i   (div_load[i]),
      .div_i    (div_in[i*CNT_W +: CNT_W]),
      .tick_o   (tick[i]),
      .clk_o    (clk_out[i]),
      .active_o (active[i])
    );
  end

endmodule

// File: tb/tb_clock_enable_bank.sv
// Directed self-checking bench for clock_enable_bank (3 channels, 24-bit).
module tb_clock_enable_bank;

  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 24;
  localparam int unsigned RDIV = 12500;

  logic              clk_in = 1'b0;
  logic              rst;
  logic              en;
  logic              sync;
  logic [NCH*CW-1:0] div_in;
  logic [NCH-1:0]    div_load;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    active;

  int total = 0;
  int bad   = 0;

  clock_enable_bank #(
    .NUM_CH    (NCH),
    .CNT_W     (CW),
    .RESET_DIV (RDIV)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .div_in   (div_in),
    .div_load (div_load),
    .tick     (tick),
    .clk_out  (clk_out),
    .active   (active)
  );

  always #5 clk_in = ~clk_in;

  // Advance one rising edge; outputs are sampled 1 ns later
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_div(input int ch, input int unsigned d);
    div_in[ch*CW +: CW] = d[CW-1:0];
  endtask

  // Loads three divisors (ch2, ch1, ch0) on one edge
  task automatic load_all(input int unsigned d2, input int unsigned d1, input int unsigned d0);
    set_div(0, d0);
    set_div(1, d1);
    set_div(2, d2);
    div_load = 3'b111;
    step();
    div_load = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sync = 1'b0; div_load = '0; div_in = '0;
    step();
    step();
    rst = 1'b0;
    total++;
    if (tick !== 3'b000) begin
      bad++; $display("FAIL reset_tick: got %b expected %b", tick, 3'b000);
    end
    total++;
    if (clk_out !== 3'b000) begin
      bad++; $display("FAIL reset_clk_out: got %b expected %b", clk_out, 3'b000);
    end
    total++;
    if (active !== 3'b111) begin
      bad++; $display("FAIL reset_active: got %b expected %b", active, 3'b111);
    end
  endtask

  task automatic test_free_run();
    int errs = 0;
    int first_n = -1;
    logic [2:0] first_t = '0, first_c = '0;
    logic [2:0] exp_t, exp_c = '0;
    int cnt[3] = '{0, 0, 0};
    for (int n = 1; n <= 60000; n++) begin
      step();
      exp_t = ((n % 12500) == 0) ? 3'b111 : 3'b000;
      if (exp_t[0]) exp_c = ~exp_c;
      for (int c = 0; c < 3; c++) if (tick[c] === 1'b1) cnt[c]++;
      if (tick !== exp_t || clk_out !== exp_c) begin
        if (errs == 0) begin first_n = n; first_t = tick; first_c = clk_out; end
        errs++;
      end
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL free_run_timing: %0d bad cycles, first at cycle %0d tick=%b clk_out=%b", errs, first_n, first_t, first_c);
    end
    for (int c = 0; c < 3; c++) begin
      total++;
      if (cnt[c] !== 4) begin
        bad++; $display("FAIL free_run_tick_count ch%0d: got %0d expected 4", c, cnt[c]);
      end
    end
    total++;
    if (active !== 3'b111) begin
      bad++; $display("FAIL free_run_active: got %b expected %b", active, 3'b111);
    end
  endtask

  // ch0 D=4, ch1 D=1, ch2 D=0
  task automatic test_load_mixed();
    logic [2:0] exp_t, exp_c;
    load_all(0, 1, 4);
    total++;
    if (tick !== 3'b000 || clk_out !== 3'b000 || active !== 3'b011) begin
      bad++;
      $display("FAIL load_edge: got tick=%b clk_out=%b active=%b expected 000 000 011", tick, clk_out, active);
    end
    for (int n = 1; n <= 16; n++) begin
      step();
      exp_t = {1'b0, 1'b1, (n % 4) == 0};
      exp_c = {1'b0, n[0], ((n / 4) % 2) == 1};
      total++;
      if (tick !== exp_t || clk_out !== exp_c) begin
        bad++;
        $display("FAIL load_mixed n=%0d: got tick=%b clk_out=%b expected tick=%b clk_out=%b", n, tick, clk_out, exp_t, exp_c);
      end
    end
    total++;
    if (active !== 3'b011) begin
      bad++; $display("FAIL load_mixed_active: got %b expected %b", active, 3'b011);
    end
  endtask

  // ch0 at cnt=3 of D=4; reload D=6 on its terminal edge
  task automatic test_load_override();
    step(); step(); step();
    set_div(0, 6);
    div_load = 3'b001;
    step();
    div_load = 3'b000;
    total++;
    if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
      bad++;
      $display("FAIL load_override_edge: got tick0=%b clk0=%b expected 0 0", tick[0], clk_out[0]);
    end
    for (int m = 1; m <= 6; m++) begin
      step();
      total++;
      if (tick[0] !== (m == 6)) begin
        bad++;
        $display("FAIL load_override m=%0d: got tick0=%b expected %b", m, tick[0], (m == 6));
      end
    end
  endtask

  task automatic test_en_hold();
    load_all(4, 4, 4);
    step(); step();
    en = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      total++;
      if (tick !== 3'b000 || clk_out !== 3'b000) begin
        bad++;
        $display("FAIL en_hold n=%0d: got tick=%b clk_out=%b expected 000 000", n, tick, clk_out);
      end
    end
    en = 1'b1;
    step();
    total++;
    if (tick !== 3'b000) begin
      bad++; $display("FAIL en_resume_1: got %b expected %b", tick, 3'b000);
    end
    step();
    total++;
    if (tick !== 3'b111 || clk_out !== 3'b111) begin
      bad++; $display("FAIL en_resume_2: got tick=%b clk_out=%b expected 111 111", tick, clk_out);
    end
  endtask

  task automatic check_sync_phase(input string tag);
    logic [2:0] exp_t;
    for (int m = 1; m <= 7; m++) begin
      step();
      exp_t = {(m % 7) == 0, (m % 5) == 0, (m % 3) == 0};
      total++;
      if (tick !== exp_t) begin
        bad++;
        $display("FAIL %s m=%0d: got tick=%b expected %b", tag, m, tick, exp_t);
      end
    end
  endtask

  // ch0 D=3, ch1 D=5, ch2 D=7
  task automatic test_sync();
    load_all(7, 5, 3);
    for (int n = 1; n <= 11; n++) step();
    total++;
    if (clk_out !== 3'b101) begin
      bad++; $display("FAIL sync_pre_clk_out: got %b expected %b", clk_out, 3'b101);
    end
    sync = 1'b1;
    step();
    sync = 1'b0;
    total++;
    if (tick !== 3'b000 || clk_out !== 3'b000) begin
      bad++; $display("FAIL sync_edge: got tick=%b clk_out=%b expected 000 000", tick, clk_out);
    end
    check_sync_phase("sync_phase");
    total++;
    if (clk_out !== 3'b110) begin
      bad++; $display("FAIL sync_post_clk_out: got %b expected %b", clk_out, 3'b110);
    end
    en = 1'b0;
    step(); step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    total++;
    if (tick !== 3'b000 || clk_out !== 3'b000) begin
      bad++; $display("FAIL sync_en_low_edge: got tick=%b clk_out=%b expected 000 000", tick, clk_out);
    end
    en = 1'b1;
    check_sync_phase("sync_en_low_phase");
  endtask

  task automatic test_reset_mid();
    int errs = 0;
    int first_n = -1;
    logic [2:0] exp_t;
    load_all(4, 4, 4);
    for (int n = 1; n <= 6; n++) step();
    total++;
    if (clk_out !== 3'b111) begin
      bad++; $display("FAIL reset_mid_pre: got clk_out=%b expected %b", clk_out, 3'b111);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (tick !== 3'b000 || clk_out !== 3'b000 || active !== 3'b111) begin
      bad++;
      $display("FAIL reset_mid_edge: got tick=%b clk_out=%b active=%b expected 000 000 111", tick, clk_out, active);
    end
    for (int n = 1; n <= 12500; n++) begin
      step();
      exp_t = (n == 12500) ? 3'b111 : 3'b000;
      if (tick !== exp_t) begin
        if (errs == 0) first_n = n;
        errs++;
      end
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL reset_mid_first_tick: %0d bad cycles, first at cycle %0d", errs, first_n);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_mixed();
    test_load_override();
    test_en_hold();
    test_sync();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
